// File: rtl/uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_feeder
// Description : Byte FIFO plus WISHBONE-style bus master that drains the FIFO
//               into the MiniUART data register, polling the line status
//               register for transmitter-ready before each byte.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_feeder #(
  parameter int unsigned DEPTH_LOG2 = 4,
  parameter logic [2:0]  OFF_DATA   = 3'b000,
  parameter logic [2:0]  OFF_LSR    = 3'b001,
  parameter int unsigned GUARD_CYC  = 3
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  input  logic                  push_i,
  input  logic [7:0]            push_data_i,
  input  logic                  flush_i,
  output logic                  full_o,
  output logic [DEPTH_LOG2:0]   count_o,
  output logic                  busy_o,
  output logic [2:0]            ADD_O,
  output logic [31:0]           DAT_O,
  input  logic [31:0]           DAT_I,
  output logic                  STB_O,
  output logic                  WE_O
);

  localparam int unsigned         DEPTH      = 1 << DEPTH_LOG2;
  localparam int unsigned         GW         = $clog2(GUARD_CYC);
  localparam logic [GW-1:0]       GUARD_LOAD = GW'(GUARD_CYC - 1);
  localparam logic [DEPTH_LOG2:0] COUNT_FULL = (DEPTH_LOG2 + 1)'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_POLL  = 2'd1,
    ST_WRITE = 2'd2,
    ST_GUARD = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [GW-1:0]           guard_q, guard_d;
  logic [DEPTH_LOG2-1:0]   wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2-1:0]   rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2:0]     count_q, count_d;
  logic [7:0]              mem_q [DEPTH];

  logic full_w;
  logic push_ok_w;
  logic pop_w;
  logic lsr_ready_w;
  logic unused_dat_w;

  // Only the transmitter-ready bit of the LSR matters here.
  assign lsr_ready_w  = DAT_I[5];
  assign unused_dat_w = ^{DAT_I[31:6], DAT_I[4:0]};

  assign full_w    = (count_q == COUNT_FULL);
  // flush wins over a concurrent push; a push while full is dropped.
  assign push_ok_w = push_i & ~full_w & ~flush_i;
  // The count guard makes a WRITE reached with an emptied FIFO harmless.
  assign pop_w     = (state_q == ST_WRITE) && (count_q != '0);

  // FIFO pointer and occupancy next-state, flush clears everything.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok_w) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_w)     rd_ptr_d = rd_ptr_q + 1'b1;
      if (push_ok_w && !pop_w)      count_d = count_q + 1'b1;
      else if (pop_w && !push_ok_w) count_d = count_q - 1'b1;
    end
  end

  // Byte storage; contents survive reset, only the pointers are cleared.
  always_ff @(posedge CLK_I) begin
    if (push_ok_w) mem_q[wr_ptr_q] <= push_data_i;
  end

  // Sequencer next-state: IDLE -> POLL until ready -> WRITE -> GUARD settle.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    unique case (state_q)
      ST_IDLE: begin
        if (count_q != '0) state_d = ST_POLL;
      end
      ST_POLL: begin
        if (flush_i || (count_q == '0)) state_d = ST_IDLE;
        else if (lsr_ready_w)           state_d = ST_WRITE;
      end
      ST_WRITE: begin
        state_d = ST_GUARD;
        guard_d = GUARD_LOAD;
      end
      ST_GUARD: begin
        if (guard_q == '0) state_d = ST_IDLE;
        else               guard_d = guard_q - 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, pointer and counter registers with asynchronous reset.
  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q  <= ST_IDLE;
      guard_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      guard_q  <= guard_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Bus outputs decoded purely from registered state and the FIFO head.
  always_comb begin
    STB_O = 1'b0;
    WE_O  = 1'b0;
    ADD_O = OFF_LSR;
    DAT_O = 32'h0;
    unique case (state_q)
      ST_POLL: STB_O = 1'b1;
      ST_WRITE: begin
        STB_O = 1'b1;
        WE_O  = 1'b1;
        ADD_O = OFF_DATA;
        DAT_O = {24'h0, mem_q[rd_ptr_q]};
      end
      default: ;
    endcase
  end

  assign full_o  = full_w;
  assign count_o = count_q;
  assign busy_o  = (count_q != '0) || (state_q != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_feeder
// Description : Self-checking bench for uart_tx_feeder: directed vector table,
//               hand-written corner sequences and randomized traffic checked
//               against a queue-based transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_feeder;

  localparam int         DEPTH     = 16;
  localparam int         GUARD_CYC = 3;
  localparam logic [2:0] OFF_DATA  = 3'b000;
  localparam logic [2:0] OFF_LSR   = 3'b001;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b0;
  logic        push_i = 1'b0;
  logic [7:0]  push_data_i = 8'h0;
  logic        flush_i = 1'b0;
  logic        full_o;
  logic [4:0]  count_o;
  logic        busy_o;
  logic [2:0]  ADD_O;
  logic [31:0] DAT_O;
  logic [31:0] DAT_I = 32'h0;
  logic        STB_O;
  logic        WE_O;

  uart_tx_feeder #(
    .DEPTH_LOG2(4), .OFF_DATA(OFF_DATA), .OFF_LSR(OFF_LSR), .GUARD_CYC(GUARD_CYC)
  ) dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .push_i(push_i), .push_data_i(push_data_i),
    .flush_i(flush_i), .full_o(full_o), .count_o(count_o), .busy_o(busy_o),
    .ADD_O(ADD_O), .DAT_O(DAT_O), .DAT_I(DAT_I), .STB_O(STB_O), .WE_O(WE_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct {
    logic        push;
    logic [7:0]  data;
    logic        rdy;
    logic        stb;
    logic        we;
    logic [2:0]  add;
    logic [31:0] dat;
    logic [4:0]  cnt;
    logic        busy;
  } vec_t;

  int nvec = 0;
  int nerr = 0;

  // Transaction model state
  logic [7:0] q[$];
  logic [7:0] wr_log[$];
  int         guard_left;
  bit         prev_poll_rdy;
  bit         prev_idle_ne;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input bit p, input logic [7:0] d, input bit rdy, input bit fl);
    push_i      = p;
    push_data_i = d;
    flush_i     = fl;
    DAT_I       = $urandom;
    DAT_I[5]    = rdy;
  endtask

  task automatic model_clear();
    q.delete();
    guard_left    = 0;
    prev_poll_rdy = 0;
    prev_idle_ne  = 0;
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, return at posedge+1.
  task automatic step(input bit tv, input vec_t v);
    bit idle;
    bit pop;
    bit acc;
    bit nxt_poll_rdy;
    bit nxt_idle_ne;
    @(negedge CLK_I);
    if (tv) begin
      chk("tbl_stb", STB_O, v.stb);
      chk("tbl_we", WE_O, v.we);
      chk("tbl_add", ADD_O, v.add);
      chk("tbl_dat", DAT_O, v.dat);
      chk("tbl_cnt", count_o, v.cnt);
      chk("tbl_busy", busy_o, v.busy);
    end
    idle = !STB_O && (guard_left == 0);
    chk("count", count_o, q.size());
    chk("full", full_o, 32'(q.size() == DEPTH));
    chk("busy", busy_o, 32'((q.size() != 0) || STB_O || (guard_left > 0)));
    if (guard_left > 0) chk("guard_stb", STB_O, 0);
    chk("wr_when_ready", STB_O && WE_O, prev_poll_rdy);
    if (prev_idle_ne) chk("poll_after_idle", STB_O && !WE_O, 1);
    pop = 0;
    if (STB_O && WE_O) begin
      chk("wr_add", ADD_O, OFF_DATA);
      chk("wr_dat", DAT_O, (q.size() != 0) ? {24'h0, q[0]} : 32'hDEAD_BEEF);
      pop = (q.size() != 0);
      wr_log.push_back(DAT_O[7:0]);
      guard_left = GUARD_CYC;
    end else begin
      chk("rd_add", ADD_O, OFF_LSR);
      chk("dat_zero", DAT_O, 0);
      if (guard_left > 0) guard_left--;
    end
    nxt_poll_rdy = STB_O && !WE_O && DAT_I[5] && !flush_i && (q.size() != 0);
    nxt_idle_ne  = idle && (q.size() != 0);
    acc = push_i && !flush_i && (q.size() < DEPTH);
    if (flush_i) q.delete();
    else begin
      if (pop) q.delete(0);
      if (acc) q.push_back(push_data_i);
    end
    prev_poll_rdy = nxt_poll_rdy;
    prev_idle_ne  = nxt_idle_ne;
    @(posedge CLK_I);
    #1;
  endtask

  task automatic run(input int n);
    vec_t v;
    v = '{default: '0};
    for (int i = 0; i < n; i++) step(0, v);
  endtask

  task automatic do_reset();
    drive(0, 8'h0, 0, 0);
    RST_I = 1'b1;
    @(posedge CLK_I);
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    model_clear();
  endtask

  function automatic vec_t mkv(bit p, logic [7:0] d, bit r, bit s, bit w,
                               logic [2:0] a, logic [31:0] dt, logic [4:0] c, bit b);
    vec_t v;
    v.push = p; v.data = d; v.rdy = r; v.stb = s; v.we = w;
    v.add = a; v.dat = dt; v.cnt = c; v.busy = b;
    return v;
  endfunction

  vec_t tbl[9];
  vec_t nv;
  int   pushed;
  int   sz_before;
  bit   pp;

  initial begin
    nv = '{default: '0};
    // Single byte with UART ready: write lands three cycles after the push.
    tbl[0] = mkv(1, 8'hA5, 1, 0, 0, 3'b001, 32'h0,  5'd0, 0);
    tbl[1] = mkv(0, 8'h00, 1, 0, 0, 3'b001, 32'h0,  5'd1, 1);
    tbl[2] = mkv(0, 8'h00, 1, 1, 0, 3'b001, 32'h0,  5'd1, 1);
    tbl[3] = mkv(0, 8'h00, 1, 1, 1, 3'b000, 32'hA5, 5'd1, 1);
    tbl[4] = mkv(0, 8'h00, 1, 0, 0, 3'b001, 32'h0,  5'd0, 1);
    tbl[5] = mkv(0, 8'h00, 1, 0, 0, 3'b001, 32'h0,  5'd0, 1);
    tbl[6] = mkv(0, 8'h00, 1, 0, 0, 3'b001, 32'h0,  5'd0, 1);
    tbl[7] = mkv(0, 8'h00, 1, 0, 0, 3'b001, 32'h0,  5'd0, 0);
    tbl[8] = mkv(0, 8'h00, 1, 0, 0, 3'b001, 32'h0,  5'd0, 0);

    // Reset then idle
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(0, nv);
      chk("idle_stb", STB_O, 0);
      chk("idle_we", WE_O, 0);
      chk("idle_add", ADD_O, 3'b001);
      chk("idle_cnt", count_o, 0);
      chk("idle_busy", busy_o, 0);
    end

    // Vector table
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].push, tbl[i].data, tbl[i].rdy, 0);
      step(1, tbl[i]);
    end

    // Back-pressure: two bytes, UART busy for 10 polls
    wr_log.delete();
    drive(1, 8'h11, 0, 0); step(0, nv);
    drive(1, 8'h22, 0, 0); step(0, nv);
    for (int i = 0; i < 10; i++) begin
      drive(0, 8'h0, 0, 0);
      chk("bp_poll_stb", STB_O, 1);
      chk("bp_poll_we", WE_O, 0);
      step(0, nv);
    end
    for (int i = 0; i < 30; i++) begin drive(0, 8'h0, 1, 0); step(0, nv); end
    chk("bp_nwr", wr_log.size(), 2);
    if (wr_log.size() == 2) begin
      chk("bp_b0", wr_log[0], 8'h11);
      chk("bp_b1", wr_log[1], 8'h22);
    end

    // Full / overflow: 17 pushes, last dropped
    wr_log.delete();
    for (int i = 0; i < 17; i++) begin drive(1, 8'(i), 0, 0); step(0, nv); end
    drive(0, 8'h0, 0, 0);
    chk("ovf_full", full_o, 1);
    chk("ovf_cnt", count_o, 16);
    for (int i = 0; i < 130; i++) begin drive(0, 8'h0, 1, 0); step(0, nv); end
    chk("ovf_nwr", wr_log.size(), 16);
    for (int i = 0; i < 16 && i < wr_log.size(); i++) chk("ovf_byte", wr_log[i], 8'(i));

    // Push during WRITE cycles keeps FIFO at 15 across pointer wrap
    wr_log.delete();
    for (int i = 0; i < 15; i++) begin drive(1, 8'(8'h40 + i), 0, 0); step(0, nv); end
    pushed = 15;
    for (int i = 0; i < 400; i++) begin
      pp = WE_O && (pushed < 40);
      drive(pp, 8'(8'h40 + pushed), 1, 0);
      if (pp) pushed++;
      sz_before = q.size();
      step(0, nv);
      if (pp) chk("pp_count", count_o, sz_before);
    end
    chk("wrap_nwr", wr_log.size(), 40);
    for (int i = 0; i < 40 && i < wr_log.size(); i++) chk("wrap_byte", wr_log[i], 8'(8'h40 + i));

    // Flush during POLL with 5 queued
    do_reset();
    wr_log.delete();
    for (int i = 0; i < 5; i++) begin drive(1, 8'(8'h80 + i), 0, 0); step(0, nv); end
    drive(0, 8'h0, 0, 1);
    chk("pre_flush_poll", STB_O && !WE_O, 1);
    step(0, nv);
    drive(0, 8'h0, 1, 0);
    chk("flush_stb", STB_O, 0);
    chk("flush_cnt", count_o, 0);
    run(15);
    chk("flush_nowr", wr_log.size(), 0);

    // Asynchronous reset during GUARD with one byte still queued
    drive(1, 8'h5A, 1, 0); step(0, nv);
    drive(1, 8'h5B, 1, 0); step(0, nv);
    drive(0, 8'h0, 1, 0);  step(0, nv);
    chk("rg_write", WE_O, 1);
    step(0, nv);
    chk("rg_guard_cnt", count_o, 1);
    RST_I = 1'b1;
    #1;
    chk("rg_stb", STB_O, 0);
    chk("rg_cnt", count_o, 0);
    chk("rg_busy", busy_o, 0);
    chk("rg_add", ADD_O, OFF_LSR);
    @(posedge CLK_I);
    #1;
    RST_I = 1'b0;
    model_clear();
    run(10);

    // Randomized traffic against the model
    for (int i = 0; i < 2000; i++) begin
      drive(bit'($urandom_range(0, 1)), 8'($urandom),
            $urandom_range(0, 2) != 0, $urandom_range(0, 63) == 0);
      step(0, nv);
    end
    for (int i = 0; i < 130; i++) begin drive(0, 8'h0, 1, 0); step(0, nv); end
    chk("rand_drain", count_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
`default_nettype wire
